// File: rtl/sbqm_pkg.sv
// Shared types, default widths and helpers for the bank queue manager wait-time path.
package sbqm_pkg;

  localparam int unsigned PEOPLE_W_DEF = 3;
  localparam int unsigned TELLER_W_DEF = 2;
  localparam int unsigned SVC_W_DEF    = 3;
  localparam int unsigned WAIT_W_DEF   = 5;
  localparam int unsigned SERVICE_DEF_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    MUL
  } state_t;

  // Clamp an unsigned value to the largest number representable in `width` bits.
  function automatic logic [31:0] saturate(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first bit is resolved in the load cycle; valid flags the cycle of the final step,
// and quotient holds the result from the following cycle until the next load. Needs DW >= 2.
module seq_divider #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          valid
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic [DW-1:0] rem;
  logic [DW-1:0] div_r;
  logic [CW-1:0] cnt;
  logic [DW-1:0] src_rem;
  logic [DW-1:0] src_q;
  logic [DW-1:0] src_div;
  logic [DW:0]   shifted;
  logic          ge;
  logic [DW-1:0] step_rem;
  logic [DW-1:0] step_q;

  // quotient doubles as the dividend shift register: bits leave at the top, quotient bits enter at the bottom
  always_comb begin
    src_rem  = load ? '0 : rem;
    src_q    = load ? dividend : quotient;
    src_div  = load ? divisor : div_r;
    shifted  = {src_rem, src_q[DW-1]};
    ge       = (shifted >= {1'b0, src_div});
    step_rem = ge ? DW'(shifted - {1'b0, src_div}) : shifted[DW-1:0];
    step_q   = {src_q[DW-2:0], ge};
  end

  assign valid = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      quotient <= '0;
      div_r    <= '0;
      cnt      <= '0;
    end else if (load) begin
      rem      <= step_rem;
      quotient <= step_q;
      div_r    <= divisor;
      cnt      <= CW'(DW - 1);
    end else if (cnt != '0) begin
      rem      <= step_rem;
      quotient <= step_q;
      cnt      <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/wait_time_calc.sv
// Estimated wait = ceil(people / tellers) * service_time, with zero-teller and overflow handling.
module wait_time_calc
  import sbqm_pkg::*;
#(
  parameter int unsigned PEOPLE_W    = PEOPLE_W_DEF,
  parameter int unsigned TELLER_W    = TELLER_W_DEF,
  parameter int unsigned SVC_W       = SVC_W_DEF,
  parameter int unsigned WAIT_W      = WAIT_W_DEF,
  parameter int unsigned SERVICE_DEF = SERVICE_DEF_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PEOPLE_W-1:0] people_count,
  input  logic [TELLER_W-1:0] teller_count,
  input  logic                start,
  input  logic                auto_mode,
  input  logic                cfg_we,
  input  logic [SVC_W-1:0]    cfg_service,
  output logic                busy,
  output logic                done,
  output logic [WAIT_W-1:0]   wait_time,
  output logic                error
);

  localparam int unsigned DW = PEOPLE_W + 1;
  localparam int unsigned PW = DW + SVC_W;

  state_t state, state_next;

  logic [SVC_W-1:0]    svc;
  logic [PEOPLE_W-1:0] snap_people;
  logic [TELLER_W-1:0] snap_tellers;
  logic [SVC_W-1:0]    snap_svc;
  logic                snap_valid;

  logic          changed;
  logic          trigger;
  logic          load;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic          div_valid;
  logic [PW-1:0] product;
  logic [WAIT_W-1:0] result;

  assign changed  = {people_count, teller_count, svc} != {snap_people, snap_tellers, snap_svc};
  assign trigger  = start || (auto_mode && (!snap_valid || changed));
  assign dividend = DW'(people_count) + DW'(teller_count) - DW'(1);
  assign divisor  = DW'(teller_count);
  assign busy     = (state != IDLE);

  seq_divider #(
    .DW(DW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .valid    (div_valid)
  );

  // Snapshot registers hold the in-flight operands and, once done, the last-computed inputs.
  assign product = PW'(quotient) * PW'(snap_svc);
  assign result  = (snap_tellers == '0) ? '1 : WAIT_W'(saturate(32'(product), WAIT_W));

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          load       = 1'b1;
          state_next = DIV;
        end
      end
      DIV:     if (div_valid) state_next = MUL;
      MUL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      svc          <= SVC_W'(SERVICE_DEF);
      snap_people  <= '0;
      snap_tellers <= '0;
      snap_svc     <= '0;
      snap_valid   <= 1'b0;
      done         <= 1'b0;
      wait_time    <= '0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_we) svc <= cfg_service;
      if (load) begin
        snap_people  <= people_count;
        snap_tellers <= teller_count;
        snap_svc     <= svc;
      end
      if (state == MUL) begin
        done       <= 1'b1;
        wait_time  <= result;
        error      <= (snap_tellers == '0);
        snap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wait_time_calc.sv
// Randomised and directed checks of wait_time_calc against an arithmetic reference model.
module tb_wait_time_calc;

  localparam int PW   = 3;
  localparam int TW   = 2;
  localparam int SW   = 3;
  localparam int WW   = 5;
  localparam int SDEF = 3;
  localparam int DW   = PW + 1;
  localparam int WMAX = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] people_count;
  logic [TW-1:0] teller_count;
  logic          start;
  logic          auto_mode;
  logic          cfg_we;
  logic [SW-1:0] cfg_service;
  logic          busy;
  logic          done;
  logic [WW-1:0] wait_time;
  logic          error;

  int total = 0;
  int bad   = 0;
  int svc_m;
  int prev_w;
  int prev_e;

  wait_time_calc #(
    .PEOPLE_W    (PW),
    .TELLER_W    (TW),
    .SVC_W       (SW),
    .WAIT_W      (WW),
    .SERVICE_DEF (SDEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .people_count (people_count),
    .teller_count (teller_count),
    .start        (start),
    .auto_mode    (auto_mode),
    .cfg_we       (cfg_we),
    .cfg_service  (cfg_service),
    .busy         (busy),
    .done         (done),
    .wait_time    (wait_time),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_wait(input int p, input int t, input int s);
    int q;
    int w;
    if (t == 0) return WMAX;
    q = p / t;
    if (p % t != 0) q++;
    w = q * s;
    return (w > WMAX) ? WMAX : w;
  endfunction

  task automatic write_svc(input int s);
    cfg_we = 1'b1;
    cfg_service = SW'(s);
    @(negedge clk);
    cfg_we = 1'b0;
    svc_m = s;
  endtask

  // Start pulse, then the full cycle-by-cycle timeline up to the done pulse.
  task automatic run_start(input int p, input int t, input bit disturb);
    int ew;
    int ee;
    ew = model_wait(p, t, svc_m);
    ee = (t == 0) ? 1 : 0;
    people_count = PW'(p);
    teller_count = TW'(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      cfg_we = 1'b1;
      cfg_service = SW'($urandom_range(0, 7));
      svc_m = int'(cfg_service);
      people_count = PW'($urandom_range(0, 7));
      teller_count = TW'($urandom_range(0, 3));
      start = 1'b1;
    end
    for (int i = 1; i <= DW; i++) begin
      check("busy", 32'(busy), 1);
      check("done_early", 32'(done), 0);
      check("hold_wait", 32'(wait_time), prev_w);
      check("hold_error", 32'(error), prev_e);
      @(negedge clk);
      cfg_we = 1'b0;
      start = 1'b0;
    end
    check("done", 32'(done), 1);
    check("busy_off", 32'(busy), 0);
    check("wait", 32'(wait_time), ew);
    check("error", 32'(error), ee);
    prev_w = ew;
    prev_e = ee;
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    rst = 1'b1;
    people_count = '0;
    teller_count = '0;
    start = 1'b0;
    auto_mode = 1'b0;
    cfg_we = 1'b0;
    cfg_service = '0;
    svc_m = SDEF;
    prev_w = 0;
    prev_e = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wait", 32'(wait_time), 0);
    check("rst_error", 32'(error), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    run_start(7, 3, 1'b0);
    run_start(0, 2, 1'b0);
    run_start(5, 2, 1'b0);
    run_start(4, 0, 1'b0);
    write_svc(7);
    run_start(7, 1, 1'b0);

    // Auto mode: new inputs trigger once, steady inputs do not.
    write_svc(3);
    people_count = PW'(2);
    teller_count = TW'(2);
    auto_mode = 1'b1;
    wait_done("auto_first_done");
    check("auto_first_wait", 32'(wait_time), model_wait(2, 2, 3));
    check("auto_first_error", 32'(error), 0);
    @(negedge clk);
    people_count = PW'(5);
    wait_done("auto_second_done");
    check("auto_second_wait", 32'(wait_time), model_wait(5, 2, 3));
    count_dones("auto_steady", 20);
    auto_mode = 1'b0;
    prev_w = model_wait(5, 2, 3);
    prev_e = 0;

    // Ignored restart, then reset mid-operation.
    people_count = PW'(4);
    teller_count = TW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_wait", 32'(wait_time), 0);
    check("abort_error", 32'(error), 0);
    svc_m = SDEF;
    prev_w = 0;
    prev_e = 0;
    count_dones("abort_no_done", 8);
    run_start(4, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) write_svc(int'($urandom_range(0, 7)));
      run_start(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
